seq_divmod: RTL and testbench
=============================

Name: seq_divmod

Overview:
- Multi-cycle unsigned divider that returns quotient and remainder of the same operand pair.
- Replaces the parallel combinational DIV + MOD pair in datapath circuits, so one shared operator drives both the remainder comparator and the quotient mux path.
- Uses a radix-2 restoring algorithm: one quotient bit per cycle, with a start/done handshake toward the HLS controller.

Parameters:
- DATAWIDTH, 64, operand, quotient and remainder width in bits (legal range 2..64).

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  DATAWIDTH  dividend (unsigned); captured on the accepting edge.
- b  input  DATAWIDTH  divisor (unsigned); captured on the accepting edge.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; quo/rem/dbz are valid from this cycle on.
- quo  output  DATAWIDTH  registered quotient.
- rem  output  DATAWIDTH  registered remainder.
- dbz  output  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE; busy=0, done=0, quo=0, rem=0, dbz=0; iteration counter=0.
- States:
  - IDLE: waits for start.
  - RUN: iterates.
  - DONE: one-cycle completion state.
- Acceptance:
  - start=1 at a rising edge in IDLE or DONE captures a and b.
  - start is ignored in RUN; no queueing, no error.
- Normal path (b≠0), start accepted at edge k:
  - Edge k: dividend shift register loaded with a, partial remainder cleared, counter=0, state→RUN, busy=1.
  - Each RUN edge: shift {R,Q} left by 1; trial = R − b (width DATAWIDTH+1).
    - If trial is non-negative: R=trial and the Q LSB=1.
    - Otherwise the Q LSB=0.
    - counter increments.
  - The DATAWIDTH-th iteration happens at edge k+DATAWIDTH. At that edge quo/rem are written, dbz=0, done=1, busy=0, state→DONE.
  - Latency: DATAWIDTH cycles from the accepting edge to done.
- Divide-by-zero (b=0 at the accepting edge k):
  - No iterations run.
  - At edge k: quo = all ones, rem = a, dbz=1, done=1, busy=0, state→DONE.
  - Latency: 1 cycle.
- DONE:
  - done=1 for exactly one cycle.
  - With start=1 there, the next operation is accepted immediately, giving back-to-back throughput of DATAWIDTH+1 cycles.
  - Otherwise state→IDLE and done returns to 0.
- Output hold: quo, rem and dbz hold their values until the next completion. They do not change at acceptance or during RUN.
- Operand stability: a and b may change freely after the accepting edge.
- Arithmetic invariant for b≠0: a = quo·b + rem and rem < b.
  - a < b gives quo=0, rem=a.
  - a=0 gives quo=0, rem=0.
- Reset mid-RUN: aborts immediately to the reset values. The in-flight result is discarded and no done is produced.

Decomposition:
- Shared package:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - helper function for the counter width, $clog2(DATAWIDTH+1).
- One natural sub-module: divmod_step. It is the combinational single-iteration cell: it takes R, the Q MSB and b, and returns next R, next Q LSB and the borrow.
- The FSM, counter and registers stay in seq_divmod.

Test Plan:
- Reset then idle, DATAWIDTH=8: assert Rst=0 mid-simulation → busy=0, done=0, quo=0, rem=0, dbz=0 asynchronously, with no clock edge needed.
- Basic division, DATAWIDTH=8: a=100, b=7, start pulse → done exactly 8 cycles after the accepting edge; quo=14, rem=2, dbz=0; busy=1 throughout those cycles.
- Divide-by-zero, DATAWIDTH=8: a=55, b=0 → done 1 cycle later; quo=255, rem=55, dbz=1.
- Boundaries, DATAWIDTH=64:
  - a=2^64−1, b=1 → quo=2^64−1, rem=0.
  - a=3, b=2^64−1 → quo=0, rem=3.
  - Each completes in 64 cycles.
- Handshake and abort:
  - start held high during RUN is ignored. With start=1 in the DONE cycle, the second op (a=9, b=4) is accepted and done arrives 8 cycles later with quo=2, rem=1.
  - Rst pulsed at iteration 4 of an op → no done pulse; outputs are 0.
- Randomised scoreboard, DATAWIDTH=16: 1000 random pairs including b=0 → check the a = quo·b + rem invariant and rem < b, or the dbz rules when b=0.

Source files
------------

// File: rtl/seq_divmod_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the iteration-counter width helper.
package seq_divmod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/divmod_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into R and
// trial-subtract the divisor; purely combinational.
module divmod_step #(
    parameter int DATAWIDTH = 64
) (
    input  logic [DATAWIDTH-1:0] r_i,
    input  logic                 q_msb_i,
    input  logic [DATAWIDTH-1:0] b_i,
    output logic [DATAWIDTH-1:0] r_o,
    output logic                 q_lsb_o,
    output logic                 borrow_o
);

    // One spare MSB so the borrow of the DATAWIDTH+1 bit subtraction is explicit.
    logic [DATAWIDTH+1:0] shifted;
    logic [DATAWIDTH+1:0] trial;
    logic                 trial_hi_unused;

    always_comb begin
        shifted  = {1'b0, r_i, q_msb_i};
        trial    = shifted - {2'b00, b_i};
        borrow_o = trial[DATAWIDTH+1];
        q_lsb_o  = ~borrow_o;
        r_o      = borrow_o ? shifted[DATAWIDTH-1:0] : trial[DATAWIDTH-1:0];
    end

    assign trial_hi_unused = ^{trial[DATAWIDTH], shifted[DATAWIDTH+1:DATAWIDTH]};

endmodule

// File: rtl/seq_divmod.sv
// Multi-cycle unsigned divider producing quotient and remainder together,
// one quotient bit per cycle, with a start/busy/done handshake.
module seq_divmod
    import seq_divmod_pkg::*;
#(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quo,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 dbz
);

    localparam int            CW        = cnt_width(DATAWIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATAWIDTH - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] r_q, r_d;
    logic [DATAWIDTH-1:0] q_q, q_d;
    logic [DATAWIDTH-1:0] b_q, b_d;
    logic [DATAWIDTH-1:0] quo_q, quo_d;
    logic [DATAWIDTH-1:0] rem_q, rem_d;
    logic                 dbz_q, dbz_d;

    logic [DATAWIDTH-1:0] step_r;
    logic                 step_q;
    logic                 step_borrow_unused;

    divmod_step #(.DATAWIDTH(DATAWIDTH)) u_step (
        .r_i      (r_q),
        .q_msb_i  (q_q[DATAWIDTH-1]),
        .b_i      (b_q),
        .r_o      (step_r),
        .q_lsb_o  (step_q),
        .borrow_o (step_borrow_unused)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            RUN: begin
                r_d   = step_r;
                q_d   = {q_q[DATAWIDTH-2:0], step_q};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    quo_d   = {q_q[DATAWIDTH-2:0], step_q};
                    rem_d   = step_r;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept; results stay put until the next completion.
                state_d = IDLE;
                if (start) begin
                    if (b == '0) begin
                        quo_d   = '1;
                        rem_d   = a;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        r_d     = '0;
                        q_d     = a;
                        b_d     = b;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign quo  = quo_q;
    assign rem  = rem_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_divmod.sv
// Directed bench for seq_divmod at widths 8, 16 and 64, with a random
// sweep at width 16 checked against the bench's own / and % results.
module tb_seq_divmod;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    logic        start8,  busy8,  done8,  dbz8;
    logic [7:0]  a8,  b8,  quo8,  rem8;
    logic        start16, busy16, done16, dbz16;
    logic [15:0] a16, b16, quo16, rem16;
    logic        start64, busy64, done64, dbz64;
    logic [63:0] a64, b64, quo64, rem64;

    seq_divmod #(.DATAWIDTH(8)) u_dm8 (
        .Clk(Clk), .Rst(Rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .quo(quo8), .rem(rem8), .dbz(dbz8)
    );
    seq_divmod #(.DATAWIDTH(16)) u_dm16 (
        .Clk(Clk), .Rst(Rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .quo(quo16), .rem(rem16), .dbz(dbz16)
    );
    seq_divmod #(.DATAWIDTH(64)) u_dm64 (
        .Clk(Clk), .Rst(Rst), .start(start64), .a(a64), .b(b64),
        .busy(busy64), .done(done64), .quo(quo64), .rem(rem64), .dbz(dbz64)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic done_of(input int w);
        case (w)
            8:       return done8;
            16:      return done16;
            default: return done64;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            8:       return busy8;
            16:      return busy16;
            default: return busy64;
        endcase
    endfunction

    function automatic logic dbz_of(input int w);
        case (w)
            8:       return dbz8;
            16:      return dbz16;
            default: return dbz64;
        endcase
    endfunction

    function automatic logic [63:0] quo_of(input int w);
        case (w)
            8:       return {56'd0, quo8};
            16:      return {48'd0, quo16};
            default: return quo64;
        endcase
    endfunction

    function automatic logic [63:0] rem_of(input int w);
        case (w)
            8:       return {56'd0, rem8};
            16:      return {48'd0, rem16};
            default: return rem64;
        endcase
    endfunction

    task automatic drive(input int w, input logic s, input logic [63:0] av, input logic [63:0] bv);
        case (w)
            8:       begin start8  = s; a8  = av[7:0];  b8  = bv[7:0];  end
            16:      begin start16 = s; a16 = av[15:0]; b16 = bv[15:0]; end
            default: begin start64 = s; a64 = av;       b64 = bv;       end
        endcase
    endtask

    // Called just after the accepting edge; n = edges until done is seen.
    task automatic wait_done(input int w, input int bound, input logic [63:0] q0,
                             input logic [63:0] r0, output int n,
                             output logic busy_ok, output logic hold_ok);
        n       = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!done_of(w) && n < bound) begin
            if (!busy_of(w)) busy_ok = 1'b0;
            if (quo_of(w) !== q0 || rem_of(w) !== r0) hold_ok = 1'b0;
            @(posedge Clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input string tag, input int w, input logic [63:0] av,
                         input logic [63:0] bv, input int lat, input logic [63:0] eq,
                         input logic [63:0] er, input logic ed);
        int          n;
        logic        busy_ok, hold_ok;
        logic [63:0] q0, r0;
        @(posedge Clk); #1;
        q0 = quo_of(w);
        r0 = rem_of(w);
        drive(w, 1'b1, av, bv);
        @(posedge Clk); #1;
        drive(w, 1'b0, 64'd0, 64'd0);
        wait_done(w, lat + 4, q0, r0, n, busy_ok, hold_ok);
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
        check({tag, "_hold"}, {63'd0, hold_ok}, 64'd1);
        check({tag, "_quo"}, quo_of(w), eq);
        check({tag, "_rem"}, rem_of(w), er);
        check({tag, "_dbz"}, {63'd0, dbz_of(w)}, {63'd0, ed});
        check({tag, "_busy_done"}, {63'd0, busy_of(w)}, 64'd0);
        @(posedge Clk); #1;
        check({tag, "_done_pulse"}, {63'd0, done_of(w)}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        busy_ok, hold_ok, seen;
        logic [63:0] av, bv, eq, er;

        drive(8, 1'b0, 64'd0, 64'd0);
        drive(16, 1'b0, 64'd0, 64'd0);
        drive(64, 1'b0, 64'd0, 64'd0);
        #1 Rst = 1'b0;
        #1;
        check("rst0_busy", {63'd0, busy8}, 64'd0);
        check("rst0_done", {63'd0, done8}, 64'd0);
        check("rst0_quo", quo_of(8), 64'd0);
        check("rst0_rem", rem_of(8), 64'd0);
        check("rst0_dbz", {63'd0, dbz8}, 64'd0);
        #20 Rst = 1'b1;

        do_op("div100_7", 8, 64'd100, 64'd7, 8, 64'd14, 64'd2, 1'b0);
        do_op("dbz55", 8, 64'd55, 64'd0, 0, 64'd255, 64'd55, 1'b1);
        do_op("a_lt_b", 8, 64'd5, 64'd9, 8, 64'd0, 64'd5, 1'b0);
        do_op("a_zero", 8, 64'd0, 64'd7, 8, 64'd0, 64'd0, 1'b0);
        do_op("a_eq_b", 8, 64'd255, 64'd255, 8, 64'd1, 64'd0, 1'b0);
        do_op("dbz200", 8, 64'd200, 64'd0, 0, 64'd255, 64'd200, 1'b1);

        // Asynchronous reset between edges must clear the held dbz result.
        @(negedge Clk); #2;
        Rst = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy8}, 64'd0);
        check("arst_done", {63'd0, done8}, 64'd0);
        check("arst_quo", quo_of(8), 64'd0);
        check("arst_rem", rem_of(8), 64'd0);
        check("arst_dbz", {63'd0, dbz8}, 64'd0);
        @(posedge Clk); #3;
        Rst = 1'b1;

        // start stays high through RUN with new operands that must be ignored.
        @(posedge Clk); #1;
        drive(8, 1'b1, 64'd20, 64'd3);
        @(posedge Clk); #1;
        drive(8, 1'b1, 64'd9, 64'd4);
        wait_done(8, 12, 64'd0, 64'd0, n, busy_ok, hold_ok);
        check("b2b1_latency", 64'(n), 64'd8);
        check("b2b1_quo", quo_of(8), 64'd6);
        check("b2b1_rem", rem_of(8), 64'd2);
        @(posedge Clk); #1;
        drive(8, 1'b0, 64'd0, 64'd0);
        wait_done(8, 12, 64'd6, 64'd2, n, busy_ok, hold_ok);
        check("b2b2_latency", 64'(n), 64'd8);
        check("b2b2_busy_run", {63'd0, busy_ok}, 64'd1);
        check("b2b2_hold", {63'd0, hold_ok}, 64'd1);
        check("b2b2_quo", quo_of(8), 64'd2);
        check("b2b2_rem", rem_of(8), 64'd1);
        @(posedge Clk); #1;

        // Abort at iteration 4: no done afterwards and outputs cleared.
        drive(8, 1'b1, 64'd200, 64'd3);
        @(posedge Clk); #1;
        drive(8, 1'b0, 64'd0, 64'd0);
        repeat (4) begin
            @(posedge Clk); #1;
        end
        check("abort_busy_before", {63'd0, busy8}, 64'd1);
        Rst = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy8}, 64'd0);
        check("abort_quo", quo_of(8), 64'd0);
        check("abort_rem", rem_of(8), 64'd0);
        check("abort_dbz", {63'd0, dbz8}, 64'd0);
        @(posedge Clk); #3;
        Rst = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge Clk); #1;
            if (done8) seen = 1'b1;
        end
        check("abort_no_done", {63'd0, seen}, 64'd0);

        do_op("w64_max_by_1", 64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64,
              64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        do_op("w64_3_by_max", 64, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64,
              64'd0, 64'd3, 1'b0);
        do_op("w64_dbz", 64, 64'h1234_5678_9ABC_DEF0, 64'd0, 0,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            av = 64'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0)
                bv = 64'd0;
            else if (i % 4 == 1)
                bv = 64'($urandom_range(1, 15));
            else
                bv = 64'($urandom_range(1, 65535));
            if (bv == 64'd0) begin
                do_op("rnd_dbz", 16, av, bv, 0, 64'hFFFF, av, 1'b1);
            end else begin
                eq = av / bv;
                er = av % bv;
                do_op("rnd", 16, av, bv, 16, eq, er, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
